// File: rtl/twin_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : twin_word_serializer
// Description : Serialises a (d1, d2) word pair into one 2*WIDTH-bit frame,
//               d1 first, one bit per clock, with frame markers, a forced
//               idle gap after each frame and a wrapping frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module twin_word_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int GAP       = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic [CNT_W-1:0] pair_count
);

  localparam int FRAME_W = 2 * WIDTH;
  localparam int BIT_W   = $clog2(FRAME_W);
  localparam int GAP_W   = $clog2(GAP + 2);

  localparam logic [BIT_W-1:0] C_LAST_BIT = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] C_PREV_BIT = BIT_W'(FRAME_W - 2);
  localparam logic [GAP_W-1:0] C_GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0]     gapcnt_q, gapcnt_d;
  logic                 ser_out_q, ser_out_d;
  logic                 ser_valid_q, ser_valid_d;
  logic                 fstart_q, fstart_d;
  logic                 fend_q, fend_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Frame image in transmit order: bit FRAME_W-1 always leaves first.
  logic [FRAME_W-1:0]   w_load;
  logic                 w_accept;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_load = {d1, d2};
    end else begin : g_lsb_first
      for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign w_load[FRAME_W-1-i] = d1[i];
        assign w_load[WIDTH-1-i]   = d2[i];
      end
    end
  endgenerate

  assign in_ready    = (state_q == S_IDLE) && rst;
  assign w_accept    = in_valid && in_ready;
  assign busy        = (state_q != S_IDLE);
  assign ser_out     = ser_out_q;
  assign ser_valid   = ser_valid_q;
  assign frame_start = fstart_q;
  assign frame_end   = fend_q;
  assign pair_count  = count_q;

  // Next-state and next-output logic; bitcnt_q is the index of the bit on ser_out.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bitcnt_d    = bitcnt_q;
    gapcnt_d    = gapcnt_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    fstart_d    = 1'b0;
    fend_d      = 1'b0;
    count_d     = count_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          state_d     = S_SHIFT;
          ser_out_d   = w_load[FRAME_W-1];
          shreg_d     = {w_load[FRAME_W-2:0], 1'b0};
          bitcnt_d    = '0;
          ser_valid_d = 1'b1;
          fstart_d    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (bitcnt_q == C_LAST_BIT) begin
          count_d  = count_q + CNT_W'(1);
          gapcnt_d = '0;
          state_d  = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          ser_out_d   = shreg_q[FRAME_W-1];
          shreg_d     = {shreg_q[FRAME_W-2:0], 1'b0};
          bitcnt_d    = bitcnt_q + BIT_W'(1);
          ser_valid_d = 1'b1;
          fend_d      = (bitcnt_q == C_PREV_BIT);
        end
      end
      S_GAP: begin
        if (gapcnt_q == C_GAP_LAST) begin
          state_d = S_IDLE;
        end else begin
          gapcnt_d = gapcnt_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any partial frame at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      gapcnt_q    <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      fstart_q    <= 1'b0;
      fend_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bitcnt_q    <= bitcnt_d;
      gapcnt_q    <= gapcnt_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      fstart_q    <= fstart_d;
      fend_q      <= fend_d;
      count_q     <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_twin_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_twin_word_serializer
// Description : Scoreboard bench for twin_word_serializer. Instance A uses the
//               default MSB-first / GAP=1 build, instance B is LSB-first with
//               GAP=0 and a 2-bit frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_twin_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0] a_d1 = '0, a_d2 = '0, b_d1 = '0, b_d2 = '0;

  logic       a_in_ready, a_ser_out, a_ser_valid, a_frame_start, a_frame_end, a_busy;
  logic [7:0] a_pair_count;
  logic       b_in_ready, b_ser_out, b_ser_valid, b_frame_start, b_frame_end, b_busy;
  logic [1:0] b_pair_count;

  twin_word_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP(1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_in_ready),
    .d1(a_d1), .d2(a_d2), .ser_out(a_ser_out), .ser_valid(a_ser_valid),
    .frame_start(a_frame_start), .frame_end(a_frame_end), .busy(a_busy),
    .pair_count(a_pair_count)
  );

  twin_word_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_in_ready),
    .d1(b_d1), .d2(b_d2), .ser_out(b_ser_out), .ser_valid(b_ser_valid),
    .frame_start(b_frame_start), .frame_end(b_frame_end), .busy(b_busy),
    .pair_count(b_pair_count)
  );

  typedef struct packed {
    logic s;
    logic fs;
    logic fe;
  } exp_t;

  exp_t        q_a[$], q_b[$];
  int          total = 0, bad = 0;
  int          cyc = 0;
  int          pc_a_exp = 0, pc_b_exp = 0;
  bit          a_pc_pend = 1'b0, b_pc_pend = 1'b0;
  int          bits_seen_a = 0;
  int          a_end_cyc = 0, a_last_gap = 0;
  logic [15:0] a_cap = '0, b_cap = '0;
  int          b_pc_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected frame: sel=0 -> instance A (MSB-first), sel=1 -> instance B (LSB-first).
  function automatic void push_frame(input bit sel, input logic [7:0] x1, input logic [7:0] x2);
    logic [15:0] f;
    exp_t        e;
    f = {x1, x2};
    for (int i = 0; i < 16; i++) begin
      e.s  = sel ? ((i < 8) ? x1[i] : x2[i-8]) : f[15-i];
      e.fs = (i == 0);
      e.fe = (i == 15);
      if (sel) q_b.push_back(e);
      else     q_a.push_back(e);
    end
  endfunction

  // Monitor: pops the scoreboard whenever a DUT presents a frame bit.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (a_pc_pend) check("a_pair_count", a_pair_count, pc_a_exp);
        a_pc_pend = 1'b0;
        if (a_ser_valid) begin
          check("a_queue_nonempty", q_a.size() > 0, 1);
          if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a_bit", {a_ser_out, a_frame_start, a_frame_end}, e);
          end
          bits_seen_a++;
          a_cap = {a_cap[14:0], a_ser_out};
          if (a_frame_start) a_last_gap = cyc - a_end_cyc;
          if (a_frame_end) begin
            a_end_cyc = cyc;
            pc_a_exp  = (pc_a_exp + 1) % 256;
            a_pc_pend = 1'b1;
          end
        end else begin
          check("a_idle_zero", {a_ser_out, a_frame_start, a_frame_end}, 0);
        end

        if (b_pc_pend) begin
          check("b_pair_count", b_pair_count, pc_b_exp);
          b_pc_hist.push_back(int'(b_pair_count));
        end
        b_pc_pend = 1'b0;
        if (b_ser_valid) begin
          check("b_queue_nonempty", q_b.size() > 0, 1);
          if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("b_bit", {b_ser_out, b_frame_start, b_frame_end}, e);
          end
          b_cap = {b_cap[14:0], b_ser_out};
          if (b_frame_end) begin
            pc_b_exp  = (pc_b_exp + 1) % 4;
            b_pc_pend = 1'b1;
          end
        end else begin
          check("b_idle_zero", {b_ser_out, b_frame_start, b_frame_end}, 0);
        end
      end
    end
  end

  task automatic send(input bit sel, input logic [7:0] x1, input logic [7:0] x2, input bit hold);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (sel) begin b_d1 = x1; b_d2 = x2; b_valid = 1'b1; end
    else     begin a_d1 = x1; a_d2 = x2; a_valid = 1'b1; end
    for (int n = 0; n < 100; n++) begin
      if (sel ? b_in_ready : a_in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", ok, 1);
    if (ok) begin
      push_frame(sel, x1, x2);
      @(posedge clk);
      #1;
    end
    if (!hold || !ok) begin
      if (sel) b_valid = 1'b0;
      else     a_valid = 1'b0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (q_a.size() == 0 && q_b.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", done, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int          base;
    bit          hit;
    int          want_hist[4];
    want_hist = '{1, 2, 3, 0};

    // Reset hold with in_valid asserted.
    rst = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_d1 = 8'hFF; a_d2 = 8'hFF; b_d1 = 8'hFF; b_d2 = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_a", {a_in_ready, a_ser_out, a_ser_valid, a_frame_start,
                           a_frame_end, a_busy, a_pair_count}, 0);
      check("rst_hold_b", {b_in_ready, b_ser_out, b_ser_valid, b_frame_start,
                           b_frame_end, b_busy, b_pair_count}, 0);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("ready_after_rst", {a_in_ready, b_in_ready}, 2'b11);
    repeat (4) @(negedge clk);
    check("no_valid_idle", {a_ser_valid, a_busy, b_ser_valid, b_busy}, 0);

    // Basic MSB-first frame, then GAP and IDLE timing.
    send(1'b0, 8'hAA, 8'h55, 1'b0);
    repeat (16) @(posedge clk);
    @(negedge clk);
    check("gap_state", {a_busy, a_in_ready, a_ser_valid}, 3'b100);
    @(negedge clk);
    check("back_idle", {a_busy, a_in_ready, a_ser_valid}, 3'b010);
    check("basic_word", a_cap, 16'b1010_1010_0101_0101);
    check("basic_count", a_pair_count, 1);

    // LSB-first frame.
    send(1'b1, 8'h01, 8'h80, 1'b0);
    drain();
    check("lsb_word", b_cap, 16'b1000_0000_0000_0001);
    check("lsb_count", b_pair_count, 1);

    // Back-to-back with in_valid held and data changed mid-frame.
    send(1'b0, 8'h11, 8'h22, 1'b1);
    send(1'b0, 8'h33, 8'h44, 1'b1);
    send(1'b0, 8'h66, 8'h77, 1'b0);
    drain();
    check("b2b_gap", a_last_gap, 3);
    check("b2b_count", a_pair_count, 4);

    // Abort after bit 5.
    base = bits_seen_a;
    send(1'b0, 8'hC3, 8'h3C, 1'b0);
    hit = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #7;
      if (bits_seen_a >= base + 6) begin
        hit = 1'b1;
        break;
      end
    end
    check("abort_reach_bit5", hit, 1);
    rst = 1'b0;
    #1;
    check("abort_outputs", {a_ser_valid, a_frame_end, a_busy, a_in_ready}, 0);
    check("abort_count_a", a_pair_count, 0);
    check("abort_count_b", b_pair_count, 0);
    q_a.delete(); q_b.delete();
    pc_a_exp = 0; pc_b_exp = 0; a_pc_pend = 1'b0; b_pc_pend = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    send(1'b0, 8'h5A, 8'hA5, 1'b0);
    drain();
    check("after_abort_word", a_cap, 16'h5AA5);
    check("after_abort_count", a_pair_count, 1);

    // Counter wrap on the 2-bit instance.
    b_pc_hist.delete();
    send(1'b1, 8'h12, 8'h34, 1'b1);
    send(1'b1, 8'h56, 8'h78, 1'b1);
    send(1'b1, 8'h9A, 8'hBC, 1'b1);
    send(1'b1, 8'hDE, 8'hF0, 1'b0);
    drain();
    check("wrap_hist_len", b_pc_hist.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < b_pc_hist.size()) check("wrap_hist", b_pc_hist[i], want_hist[i]);
    end
    check("wrap_final", b_pair_count, 0);

    check("scoreboard_empty", q_a.size() + q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
